// File: rtl/shake_absorb_squeeze_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : shake_absorb_squeeze_pkg
//  Description : Shared constants, FSM encoding and lane helpers for the
//                SHAKE128/256 sponge front end.
//  Revision    : 1.0  initial release
// ============================================================================
package shake_absorb_squeeze_pkg;

    localparam int DIN_W       = 32;
    localparam int DOUT_W      = 64;
    localparam int STATE_W     = 1600;
    localparam int STATE_BYTES = STATE_W / 8;

    // Rates in bytes for the two SHAKE variants
    localparam int RATE128_B = 168;
    localparam int RATE256_B = 136;

    // Domain-separation byte and final pad bit
    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ABSORB  = 3'd1,
        ST_PAD     = 3'd2,
        ST_PERM    = 3'd3,
        ST_SQUEEZE = 3'd4
    } shake_state_e;

    // Rate in bytes for the selected mode (0 = SHAKE128, 1 = SHAKE256)
    function automatic logic [7:0] rate_bytes(input logic mode);
        return mode ? 8'(RATE256_B) : 8'(RATE128_B);
    endfunction

    // Index of the 32-bit slot that completes a rate block
    function automatic logic [5:0] last_word_idx(input logic mode);
        return mode ? 6'(RATE256_B / 4 - 1) : 6'(RATE128_B / 4 - 1);
    endfunction

    // Index of the last 64-bit lane inside the rate
    function automatic logic [4:0] last_lane_idx(input logic mode);
        return mode ? 5'(RATE256_B / 8 - 1) : 5'(RATE128_B / 8 - 1);
    endfunction

    // Little-endian 64-bit lane extraction from the Keccak state
    function automatic logic [DOUT_W-1:0] get_lane(input logic [STATE_W-1:0] s,
                                                   input logic [4:0]         idx);
        return s[int'(idx)*DOUT_W +: DOUT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/shake_pad.sv
`default_nettype none
// ============================================================================
//  Module      : shake_pad
//  Description : Byte masking of the last message word and generation of the
//                SHAKE pad vector (0x1F after the message, 0x80 at rate end,
//                merged to 0x9F when both land on the same byte).
//  Revision    : 1.0  initial release
// ============================================================================
module shake_pad
    import shake_absorb_squeeze_pkg::*;
(
    input  logic [DIN_W-1:0]   word_i,
    input  logic [1:0]         byte_num_i,
    input  logic               is_last_i,
    input  logic               pad_en_i,
    input  logic [7:0]         pad_pos_i,
    input  logic [7:0]         rate_b_i,
    output logic [DIN_W-1:0]   word_o,
    output logic [STATE_W-1:0] pad_vec_o
);

    logic [7:0] w_end_pos;

    assign w_end_pos = rate_b_i - 8'd1;

    genvar gb;
    generate
        // Bytes beyond byte_num in the last word never reach the state
        for (gb = 0; gb < DIN_W / 8; gb++) begin : g_word_byte
            assign word_o[gb*8 +: 8] = (!is_last_i || (2'(gb) <= byte_num_i))
                                       ? word_i[gb*8 +: 8] : 8'h00;
        end

        // One pad byte per state byte; the two pad patterns share no bits,
        // so OR-ing them gives 0x9F on coincidence
        for (gb = 0; gb < STATE_BYTES; gb++) begin : g_pad_byte
            logic w_ds;
            logic w_end;
            assign w_ds  = pad_en_i && (pad_pos_i == 8'(gb));
            assign w_end = pad_en_i && (w_end_pos == 8'(gb));
            assign pad_vec_o[gb*8 +: 8] = (w_ds  ? DS_SHAKE : 8'h00)
                                        | (w_end ? PAD_END  : 8'h00);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/shake_absorb_squeeze.sv
`default_nettype none
// ============================================================================
//  Module      : shake_absorb_squeeze
//  Description : SHAKE128/256 sponge front end. Absorbs 32-bit words, pads,
//                drives an external keccak_f1600 core and squeezes 64-bit
//                lanes back to the controller.
//  Revision    : 1.0  initial release
// ============================================================================
module shake_absorb_squeeze
    import shake_absorb_squeeze_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               sha_in_ready,
    input  logic [DIN_W-1:0]   sha_din,
    input  logic               sha_is_last,
    input  logic [1:0]         sha_byte_num,
    input  logic               sha_mode,
    input  logic               sha_squeeze,
    input  logic               sha_sha_hold,
    output logic               sha_out_ready,
    output logic [DOUT_W-1:0]  sha_dout,
    output logic               sha_busy,
    output logic               perm_start,
    output logic [STATE_W-1:0] perm_state_o,
    input  logic [STATE_W-1:0] perm_state_i,
    input  logic               perm_done
);

    shake_state_e       state_q, state_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [5:0]         widx_q, widx_d;
    logic [4:0]         lidx_q, lidx_d;
    logic               mode_q, mode_d;
    logic               from_full_q, from_full_d;   // PERM entered from a full absorb block
    logic               pad_pend_q, pad_pend_d;     // PAD still owed after that block
    logic [7:0]         pad_pos_q, pad_pos_d;
    logic               perm_first_q, perm_first_d; // first cycle of PERM

    logic               w_is_idle;
    logic               w_mode_eff;
    logic [5:0]         w_slot;
    logic               w_slot_full;
    logic [DIN_W-1:0]   w_word_masked;
    logic [STATE_W-1:0] w_word_vec;
    logic [STATE_W-1:0] w_pad_vec;

    assign w_is_idle   = (state_q == ST_IDLE);
    assign w_mode_eff  = w_is_idle ? sha_mode : mode_q;
    assign w_slot      = w_is_idle ? 6'd0 : widx_q;
    assign w_slot_full = (w_slot == last_word_idx(w_mode_eff));
    assign w_word_vec  = STATE_W'(w_word_masked) << {w_slot, 5'b00000};

    shake_pad u_pad (
        .word_i     (sha_din),
        .byte_num_i (sha_byte_num),
        .is_last_i  (sha_is_last),
        .pad_en_i   (state_q == ST_PAD),
        .pad_pos_i  (pad_pos_q),
        .rate_b_i   (rate_bytes(mode_q)),
        .word_o     (w_word_masked),
        .pad_vec_o  (w_pad_vec)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            st_q         <= '0;
            widx_q       <= '0;
            lidx_q       <= '0;
            mode_q       <= 1'b0;
            from_full_q  <= 1'b0;
            pad_pend_q   <= 1'b0;
            pad_pos_q    <= '0;
            perm_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            st_q         <= st_d;
            widx_q       <= widx_d;
            lidx_q       <= lidx_d;
            mode_q       <= mode_d;
            from_full_q  <= from_full_d;
            pad_pend_q   <= pad_pend_d;
            pad_pos_q    <= pad_pos_d;
            perm_first_q <= perm_first_d;
        end
    end

    // Next-state and datapath update for absorb, pad, permute and squeeze
    always_comb begin
        state_d      = state_q;
        st_d         = st_q;
        widx_d       = widx_q;
        lidx_d       = lidx_q;
        mode_d       = mode_q;
        from_full_d  = from_full_q;
        pad_pend_d   = pad_pend_q;
        pad_pos_d    = pad_pos_q;
        perm_first_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_ABSORB: begin
                if (w_is_idle) begin
                    st_d        = '0;
                    widx_d      = '0;
                    lidx_d      = '0;
                    from_full_d = 1'b0;
                    pad_pend_d  = 1'b0;
                    pad_pos_d   = '0;
                end
                if (sha_in_ready) begin
                    if (w_is_idle) begin
                        mode_d = sha_mode;
                    end
                    st_d = st_d ^ w_word_vec;
                    if (!sha_is_last) begin
                        if (w_slot_full) begin
                            state_d      = ST_PERM;
                            perm_first_d = 1'b1;
                            from_full_d  = 1'b1;
                            widx_d       = '0;
                        end else begin
                            state_d = ST_ABSORB;
                            widx_d  = w_slot + 6'd1;
                        end
                    end else if (w_slot_full && (sha_byte_num == 2'd3)) begin
                        // Message ends exactly on the rate: padding goes
                        // into a fresh block after this permutation
                        state_d      = ST_PERM;
                        perm_first_d = 1'b1;
                        from_full_d  = 1'b1;
                        pad_pend_d   = 1'b1;
                        pad_pos_d    = 8'd0;
                        widx_d       = '0;
                    end else begin
                        state_d   = ST_PAD;
                        pad_pos_d = {w_slot, 2'b00} + 8'(sha_byte_num) + 8'd1;
                    end
                end
            end

            ST_PAD: begin
                st_d         = st_q ^ w_pad_vec;
                state_d      = ST_PERM;
                perm_first_d = 1'b1;
                pad_pend_d   = 1'b0;
                from_full_d  = 1'b0;
            end

            ST_PERM: begin
                if (perm_done) begin
                    st_d = perm_state_i;
                    if (from_full_q) begin
                        from_full_d = 1'b0;
                        state_d     = pad_pend_q ? ST_PAD : ST_ABSORB;
                    end else begin
                        state_d = ST_SQUEEZE;
                        lidx_d  = '0;
                    end
                end
            end

            ST_SQUEEZE: begin
                if (!sha_sha_hold) begin
                    if (!sha_squeeze) begin
                        state_d = ST_IDLE;
                        st_d    = '0;
                        widx_d  = '0;
                        lidx_d  = '0;
                    end else if (lidx_q == last_lane_idx(mode_q)) begin
                        state_d      = ST_PERM;
                        perm_first_d = 1'b1;
                        from_full_d  = 1'b0;
                        lidx_d       = '0;
                    end else begin
                        lidx_d = lidx_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and permutation-core outputs
    always_comb begin
        sha_busy      = (state_q == ST_PAD) || (state_q == ST_PERM) || (state_q == ST_SQUEEZE);
        sha_out_ready = (state_q == ST_SQUEEZE) && !sha_sha_hold;
        sha_dout      = get_lane(st_q, lidx_q);
        perm_start    = (state_q == ST_PERM) && perm_first_q;
        perm_state_o  = st_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_shake_absorb_squeeze.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shake_absorb_squeeze
//  Description : Directed bench for the SHAKE sponge front end with a
//                behavioural permutation stub (identity / zero / counter).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shake_absorb_squeeze;

    logic          clk = 1'b0;
    logic          reset;
    logic          sha_in_ready, sha_is_last, sha_mode, sha_squeeze, sha_sha_hold;
    logic [31:0]   sha_din;
    logic [1:0]    sha_byte_num;
    logic          sha_out_ready, sha_busy, perm_start, perm_done;
    logic [63:0]   sha_dout;
    logic [1599:0] perm_state_o, perm_state_i;

    always #5 clk = ~clk;

    shake_absorb_squeeze dut (
        .clk(clk), .reset(reset),
        .sha_in_ready(sha_in_ready), .sha_din(sha_din), .sha_is_last(sha_is_last),
        .sha_byte_num(sha_byte_num), .sha_mode(sha_mode), .sha_squeeze(sha_squeeze),
        .sha_sha_hold(sha_sha_hold), .sha_out_ready(sha_out_ready), .sha_dout(sha_dout),
        .sha_busy(sha_busy), .perm_start(perm_start), .perm_state_o(perm_state_o),
        .perm_state_i(perm_state_i), .perm_done(perm_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- permutation stub (latency 3) ----------------
    int            stub_mode = 0;   // 0 identity, 1 all-zero, 2 counter pattern
    int            stub_n    = 0;   // number of perm_start seen
    int            stub_cnt;
    logic [1599:0] stub_hold;

    function automatic logic [1599:0] stub_out(input logic [1599:0] s, input int mode, input int n);
        logic [1599:0] r;
        r = '0;
        if (mode == 0) r = s;
        else if (mode == 2) begin
            for (int k = 0; k < 25; k++) r[k*64 +: 64] = {n[31:0], 32'(k)};
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            perm_done    <= 1'b0;
            perm_state_i <= '0;
            stub_cnt     <= 0;
        end else begin
            perm_done <= 1'b0;
            if (perm_start) begin
                stub_hold <= perm_state_o;
                stub_cnt  <= 3;
                stub_n    <= stub_n + 1;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    perm_done    <= 1'b1;
                    perm_state_i <= stub_out(stub_hold, stub_mode, stub_n);
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int            perm_cnt = 0;
    logic [63:0]   lanes[$];
    logic [1599:0] caps[$];

    always @(negedge clk) begin
        if (sha_out_ready) lanes.push_back(sha_dout);
        if (perm_start) begin
            perm_cnt = perm_cnt + 1;
            caps.push_back(perm_state_o);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [63:0] lane_of(input logic [1599:0] s, input int k);
        return s[k*64 +: 64];
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] bn);
        int g = 0;
        while (sha_busy && g < 500) begin tick(); g++; end
        if (g >= 500) begin
            n_total++;
            $display("FAIL send_wait: busy=1 after 500 cycles, expected 0");
        end
        sha_din = d; sha_is_last = last; sha_byte_num = bn; sha_in_ready = 1'b1;
        tick();
        sha_in_ready = 1'b0; sha_is_last = 1'b0; sha_byte_num = 2'd0; sha_din = '0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (sha_busy && g < 1000) begin tick(); g++; end
        if (g >= 1000) begin
            n_total++;
            $display("FAIL idle_wait: busy=1 after 1000 cycles, expected 0");
        end
    endtask

    function automatic logic [63:0] q_at(input int i);
        return (i < lanes.size()) ? lanes[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [1599:0] cap_at(input int i);
        return (i < caps.size()) ? caps[i] : {1600{1'b1}};
    endfunction

    // ---------------- single-word vector table ----------------
    typedef struct {
        logic        mode;
        logic [31:0] din;
        logic [1:0]  bn;
        int          end_lane;
        logic [63:0] exp_lane0;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gap;
        int g;
        int p2;

        vt[0] = '{1'b0, 32'h0000_00AB, 2'd0, 20, 64'h0000_0000_0000_1FAB};
        vt[1] = '{1'b0, 32'h1234_ABCD, 2'd1, 20, 64'h0000_0000_001F_ABCD};
        vt[2] = '{1'b1, 32'hDEAD_BEEF, 2'd2, 16, 64'h0000_0000_1FAD_BEEF};
        vt[3] = '{1'b1, 32'hCAFE_F00D, 2'd3, 16, 64'h0000_001F_CAFE_F00D};
        vt[4] = '{1'b0, 32'hFFFF_FFFF, 2'd3, 20, 64'h0000_001F_FFFF_FFFF};

        reset = 1'b1;
        sha_in_ready = 1'b0; sha_din = '0; sha_is_last = 1'b0; sha_byte_num = 2'd0;
        sha_mode = 1'b0; sha_squeeze = 1'b0; sha_sha_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check64("rst_out_ready", 64'(sha_out_ready), 64'd0);
        check64("rst_busy",      64'(sha_busy),      64'd0);
        check64("rst_perm_start",64'(perm_start),    64'd0);
        check64("rst_dout",      sha_dout,           64'd0);
        check64("rst_state_any", 64'(|perm_state_o), 64'd0);
        reset = 1'b0;
        tick();

        // table: one word, squeeze=0, identity perm
        stub_mode = 0;
        for (int i = 0; i < 5; i++) begin
            lanes.delete(); caps.delete();
            base = perm_cnt;
            sha_mode = vt[i].mode; sha_squeeze = 1'b0; sha_sha_hold = 1'b0;
            send_word(vt[i].din, 1'b1, vt[i].bn);
            wait_idle();
            check64($sformatf("v%0d_nlanes", i), 64'(lanes.size()), 64'd1);
            check64($sformatf("v%0d_dout", i), q_at(0), vt[i].exp_lane0);
            check64($sformatf("v%0d_nperm", i), 64'(perm_cnt - base), 64'd1);
            check64($sformatf("v%0d_perm_lane0", i), lane_of(cap_at(0), 0), vt[i].exp_lane0);
            check64($sformatf("v%0d_perm_end", i), lane_of(cap_at(0), vt[i].end_lane),
                    64'h8000_0000_0000_0000);
        end

        // SHAKE256, 34 full words: pad lands in a fresh block (zero stub)
        stub_mode = 1;
        lanes.delete(); caps.delete();
        base = perm_cnt;
        sha_mode = 1'b1; sha_squeeze = 1'b0;
        for (int i = 0; i < 33; i++) send_word(32'hFFFF_FFFF, 1'b0, 2'd0);
        send_word(32'hFFFF_FFFF, 1'b1, 2'd3);
        gap = 0; g = 0;
        while (lanes.size() == 0 && g < 500) begin
            if (!sha_busy) gap++;
            tick(); g++;
        end
        wait_idle();
        check64("full_busy_gap", 64'(gap), 64'd0);
        check64("full_nperm", 64'(perm_cnt - base), 64'd2);
        check64("full_blk1_lane0", lane_of(cap_at(0), 0), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("full_blk1_lane16", lane_of(cap_at(0), 16), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("full_blk1_lane17", lane_of(cap_at(0), 17), 64'd0);
        check64("full_blk2_lane0", lane_of(cap_at(1), 0), 64'h0000_0000_0000_001F);
        check64("full_blk2_lane1", lane_of(cap_at(1), 1), 64'd0);
        check64("full_blk2_lane16", lane_of(cap_at(1), 16), 64'h8000_0000_0000_0000);
        check64("full_nlanes", 64'(lanes.size()), 64'd1);
        check64("full_dout", q_at(0), 64'd0);

        // SHAKE256, message ends at byte 134: 0x1F and 0x80 merge at byte 135
        stub_mode = 0;
        lanes.delete(); caps.delete();
        base = perm_cnt;
        sha_mode = 1'b1;
        for (int i = 0; i < 33; i++) send_word(32'hFFFF_FFFF, 1'b0, 2'd0);
        send_word(32'hFFFF_FFFF, 1'b1, 2'd2);
        wait_idle();
        check64("coinc_nperm", 64'(perm_cnt - base), 64'd1);
        check64("coinc_lane16", lane_of(cap_at(0), 16), 64'h9FFF_FFFF_FFFF_FFFF);
        check64("coinc_lane15", lane_of(cap_at(0), 15), 64'hFFFF_FFFF_FFFF_FFFF);
        check64("coinc_lane17", lane_of(cap_at(0), 17), 64'd0);
        check64("coinc_dout", q_at(0), 64'hFFFF_FFFF_FFFF_FFFF);

        // SHAKE128 continuous squeeze with hold toggling (counter stub)
        stub_mode = 2;
        lanes.delete(); caps.delete();
        base = perm_cnt;
        sha_mode = 1'b0; sha_squeeze = 1'b1; sha_sha_hold = 1'b0;
        send_word(32'h0000_00AB, 1'b1, 2'd0);
        g = 0;
        while (sha_busy && g < 400) begin
            tick(); g++;
            sha_sha_hold = ~sha_sha_hold;
            if (lanes.size() >= 30) sha_squeeze = 1'b0;
        end
        sha_sha_hold = 1'b0; sha_squeeze = 1'b0;
        check64("sq_idle", 64'(sha_busy), 64'd0);
        check64("sq_nlanes", 64'(lanes.size()), 64'd31);
        check64("sq_nperm", 64'(perm_cnt - base), 64'd2);
        for (int i = 0; i < lanes.size(); i++) begin
            check64($sformatf("sq_lane%0d", i), lanes[i],
                    {32'(base + 1 + i / 21), 32'(i % 21)});
        end

        // asynchronous reset in the middle of a permutation
        stub_mode = 0;
        lanes.delete(); caps.delete();
        base = perm_cnt;
        sha_mode = 1'b0; sha_squeeze = 1'b0;
        send_word(32'h0000_00AB, 1'b1, 2'd0);
        g = 0;
        while (perm_cnt == base && g < 50) begin tick(); g++; end
        check64("rst_mid_inperm", 64'(sha_busy), 64'd1);
        reset = 1'b1;
        #1;
        check64("rst_mid_busy",      64'(sha_busy),      64'd0);
        check64("rst_mid_out_ready", 64'(sha_out_ready), 64'd0);
        check64("rst_mid_perm_start",64'(perm_start),    64'd0);
        check64("rst_mid_state_any", 64'(|perm_state_o), 64'd0);
        check64("rst_mid_dout",      sha_dout,           64'd0);
        tick(); tick();
        reset = 1'b0;
        p2 = perm_cnt;
        lanes.delete(); caps.delete();
        repeat (10) tick();
        check64("rst_no_perm", 64'(perm_cnt - p2), 64'd0);
        check64("rst_no_lane", 64'(lanes.size()), 64'd0);
        sha_mode = vt[1].mode;
        send_word(vt[1].din, 1'b1, vt[1].bn);
        wait_idle();
        check64("rst_after_nlanes", 64'(lanes.size()), 64'd1);
        check64("rst_after_dout", q_at(0), vt[1].exp_lane0);
        check64("rst_after_end", lane_of(cap_at(0), 20), 64'h8000_0000_0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
